// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared funct3 codes, NOP encoding and memory FSM states
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for stores and extension for loads
module mem_lane_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_al,
  output logic        misalign,
  output logic        illegal,
  output logic [31:0] rdata_ext
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  // store lane enables, replicated write data and access-legality flags
  always_comb begin
    byte_en  = 4'b0000;
    wdata_al = wdata;
    misalign = 1'b0;
    illegal  = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        byte_en  = 4'b0001 << addr_lo;
        wdata_al = {4{wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_al = {2{wdata[15:0]}};
        misalign = addr_lo[0];
      end
      F3_W: begin
        byte_en  = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
    // unsigned variants only exist for loads
    if (we && (funct3 == F3_BU || funct3 == F3_HU)) illegal = 1'b1;
  end

  // pick the addressed byte/half out of the raw word and extend it
  always_comb begin
    sel_b = raw[{addr_lo, 3'b000} +: 8];
    sel_h = addr_lo[1] ? raw[31:16] : raw[15:0];
    case (funct3)
      F3_B:    rdata_ext = {{24{sel_b[7]}}, sel_b};
      F3_BU:   rdata_ext = {24'h0, sel_b};
      F3_H:    rdata_ext = {{16{sel_h[15]}}, sel_h};
      F3_HU:   rdata_ext = {16'h0, sel_h};
      F3_W:    rdata_ext = raw;
      default: rdata_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/riscv_mem_ctrl.sv
// rtl/riscv_mem_ctrl.sv - unified I/D RAM with comb fetch port and wait-stated data port
module riscv_mem_ctrl
  import riscv_pkg::*;
#(
  parameter int    MEM_BYTES   = 256,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err
);

  localparam int AW    = $clog2(MEM_BYTES);
  localparam int DEPTH = MEM_BYTES / 4;
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

  logic [31:0] mem [DEPTH];

  mem_state_t  state, state_nx;
  logic [3:0]  wcnt;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr, r_wdata;

  logic        accept, enter_resp, do_write, fault, out_of_range;
  logic        c_we;
  logic [2:0]  c_f3;
  logic [31:0] c_addr, c_wdata;
  logic [AW-3:0] c_idx;
  logic [3:0]  byte_en;
  logic [31:0] wdata_al, rdata_ext, raw;
  logic        misalign, illegal;

  assign d_ready = (state == IDLE);
  assign accept  = d_req && d_ready;

  // zero-wait accesses complete on the accept edge, so use live inputs in IDLE
  assign c_we    = (state == IDLE) ? d_we     : r_we;
  assign c_f3    = (state == IDLE) ? d_funct3 : r_f3;
  assign c_addr  = (state == IDLE) ? d_addr   : r_addr;
  assign c_wdata = (state == IDLE) ? d_wdata  : r_wdata;

  assign c_idx        = c_addr[AW-1:2];
  assign out_of_range = |c_addr[31:AW];
  assign raw          = mem[c_idx];

  mem_lane_align u_align (
    .funct3    (c_f3),
    .we        (c_we),
    .addr_lo   (c_addr[1:0]),
    .wdata     (c_wdata),
    .raw       (raw),
    .byte_en   (byte_en),
    .wdata_al  (wdata_al),
    .misalign  (misalign),
    .illegal   (illegal),
    .rdata_ext (rdata_ext)
  );

  assign fault    = out_of_range | misalign | illegal;
  assign do_write = enter_resp && c_we && !fault && rst_n;

  assign i_rdata = (|i_addr[31:AW]) ? NOP_INSTR : mem[i_addr[AW-1:2]];

  // next state; flag the transition into RESP where the access takes effect
  always_comb begin
    state_nx   = state;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_nx   = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (wcnt == 4'd0) begin
          state_nx   = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // capture the request on accept and count down the wait states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt    <= 4'd0;
      r_we    <= 1'b0;
      r_f3    <= 3'd0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
    end else if (accept) begin
      wcnt    <= WS_LOAD;
      r_we    <= d_we;
      r_f3    <= d_funct3;
      r_addr  <= d_addr;
      r_wdata <= d_wdata;
    end else if (state == WAIT && wcnt != 4'd0) begin
      wcnt <= wcnt - 4'd1;
    end
  end

  // registered response: one-cycle rvalid pulse with load data and fault flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_rvalid <= 1'b0;
      d_rdata  <= 32'h0;
      d_err    <= 1'b0;
    end else begin
      d_rvalid <= enter_resp;
      if (enter_resp) begin
        d_err   <= fault;
        d_rdata <= (fault || c_we) ? 32'h0 : rdata_ext;
      end
    end
  end

  // byte-masked RAM write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[c_idx][8*i +: 8] <= wdata_al[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_ctrl.sv
// tb/tb_riscv_mem_ctrl.sv - directed vector bench for riscv_mem_ctrl at 0 and 3 wait states
module tb_riscv_mem_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req3 = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_funct3 = 3'd0;
  logic [31:0] d_addr = 32'h0, d_wdata = 32'h0;
  logic [31:0] i_addr0 = 32'h0, i_addr3 = 32'h0;
  logic [31:0] i_rdata0, i_rdata3, rdata0, rdata3;
  logic        ready0, ready3, rvalid0, rvalid3, err0, err3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  riscv_mem_ctrl #(.MEM_BYTES(256), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .i_addr(i_addr0), .i_rdata(i_rdata0),
    .d_req(req0), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(ready0), .d_rvalid(rvalid0), .d_rdata(rdata0), .d_err(err0)
  );

  riscv_mem_ctrl #(.MEM_BYTES(256), .WAIT_STATES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .i_addr(i_addr3), .i_rdata(i_rdata3),
    .d_req(req3), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(ready3), .d_rvalid(rvalid3), .d_rdata(rdata3), .d_err(err3)
  );

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one request on the chosen instance; returns response and cycles from accept to rvalid
  task automatic txn(input bit w3, input bit we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
    if (w3) req3 = 1'b1; else req0 = 1'b1;
    @(posedge clk);
    #1;
    req0 = 1'b0; req3 = 1'b0;
    d_we = ~we; d_funct3 = 3'd7; d_addr = 32'hFFFF_FFFF; d_wdata = 32'h5A5A_5A5A;
    lat = 0; rd = 32'h0; er = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (w3 ? rvalid3 : rvalid0) begin
        rd = w3 ? rdata3 : rdata0;
        er = w3 ? err3 : err0;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          stray;

    vecs.push_back('{1, F3_W,  32'h10,  32'hDEADBEEF, 32'h0,        0});
    vecs.push_back('{0, F3_W,  32'h10,  32'h0,        32'hDEADBEEF, 0});
    vecs.push_back('{1, F3_W,  32'h20,  32'h0,        32'h0,        0});
    vecs.push_back('{1, F3_B,  32'h21,  32'h12345680, 32'h0,        0});
    vecs.push_back('{0, F3_B,  32'h21,  32'h0,        32'hFFFFFF80, 0});
    vecs.push_back('{0, F3_BU, 32'h21,  32'h0,        32'h00000080, 0});
    vecs.push_back('{0, F3_W,  32'h20,  32'h0,        32'h00008000, 0});
    vecs.push_back('{1, F3_W,  32'h2C,  32'hCAFEF00D, 32'h0,        0});
    vecs.push_back('{1, F3_H,  32'h2E,  32'hABCD1234, 32'h0,        0});
    vecs.push_back('{0, F3_H,  32'h2E,  32'h0,        32'h00001234, 0});
    vecs.push_back('{0, F3_HU, 32'h2C,  32'h0,        32'h0000F00D, 0});
    vecs.push_back('{0, F3_H,  32'h2C,  32'h0,        32'hFFFFF00D, 0});
    vecs.push_back('{0, F3_H,  32'h2F,  32'h0,        32'h0,        1});
    vecs.push_back('{1, F3_H,  32'h2D,  32'hFFFF,     32'h0,        1});
    vecs.push_back('{0, F3_W,  32'h2C,  32'h0,        32'h1234F00D, 0});
    vecs.push_back('{0, F3_W,  32'h12,  32'h0,        32'h0,        1});
    vecs.push_back('{0, F3_W,  32'h100, 32'h0,        32'h0,        1});
    vecs.push_back('{0, 3'd3,  32'h10,  32'h0,        32'h0,        1});
    vecs.push_back('{0, 3'd6,  32'h10,  32'h0,        32'h0,        1});
    vecs.push_back('{0, 3'd7,  32'h10,  32'h0,        32'h0,        1});
    vecs.push_back('{1, F3_BU, 32'h10,  32'h0,        32'h0,        1});
    vecs.push_back('{1, F3_B,  32'h103, 32'h0,        32'h0,        1});
    vecs.push_back('{0, F3_W,  32'h10,  32'h0,        32'hDEADBEEF, 0});
    vecs.push_back('{1, F3_B,  32'h13,  32'h77,       32'h0,        0});
    vecs.push_back('{0, F3_W,  32'h10,  32'h0,        32'h77ADBEEF, 0});
    vecs.push_back('{0, F3_B,  32'h13,  32'h0,        32'h00000077, 0});
    vecs.push_back('{0, F3_HU, 32'h12,  32'h0,        32'h000077AD, 0});

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_ready0", 32'(ready0), 32'h1);
    chk("rst_rvalid0", 32'(rvalid0), 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_err0", 32'(err0), 32'h0);
    chk("rst_ready3", 32'(ready3), 32'h1);
    rst_n = 1'b1;

    // zero-wait vector table
    foreach (vecs[i]) begin
      txn(0, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd1);
      chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].err));
      if (!vecs[i].we || vecs[i].err) chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
    end

    // fetch port
    @(negedge clk);
    i_addr0 = 32'h10;  #1 chk("fetch_10", i_rdata0, 32'h77ADBEEF);
    i_addr0 = 32'h12;  #1 chk("fetch_12", i_rdata0, 32'h77ADBEEF);
    i_addr0 = 32'h100; #1 chk("fetch_oor", i_rdata0, NOP_INSTR);
    i_addr0 = 32'hFFFF_FFFC; #1 chk("fetch_top", i_rdata0, NOP_INSTR);

    // store visible on fetch in the response cycle
    txn(0, 1, F3_W, 32'h40, 32'h0, rd, er, lat);
    i_addr0 = 32'h40;
    txn(0, 1, F3_W, 32'h40, 32'hA5A5A5A5, rd, er, lat);
    chk("fetch_after_commit", i_rdata0, 32'hA5A5A5A5);

    // three wait states
    txn(1, 1, F3_W, 32'h50, 32'h13572468, rd, er, lat);
    chk("w3_store_lat", 32'(lat), 32'd4);
    chk("w3_store_err", 32'(er), 32'h0);
    @(negedge clk);
    d_we = 1'b0; d_funct3 = F3_W; d_addr = 32'h50; req3 = 1'b1;
    chk("w3_ready_pre", 32'(ready3), 32'h1);
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 4) chk($sformatf("w3_ready_k%0d", k), 32'(ready3), 32'h0);
      else        chk("w3_ready_k5", 32'(ready3), 32'h1);
      chk($sformatf("w3_rvalid_k%0d", k), 32'(rvalid3), (k == 4) ? 32'h1 : 32'h0);
      if (k == 4) chk("w3_rdata", rdata3, 32'h13572468);
    end
    @(posedge clk);
    #1 req3 = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (rvalid3) break;
    end
    chk("w3_second_lat", 32'(lat), 32'd4);

    // reset while a store is waiting
    @(negedge clk);
    d_we = 1'b1; d_funct3 = F3_W; d_addr = 32'h50; d_wdata = 32'hFFFFFFFF; req3 = 1'b1;
    @(posedge clk);
    #1 req3 = 1'b0;
    @(negedge clk);
    chk("rw_in_wait", 32'(ready3), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rw_ready", 32'(ready3), 32'h1);
    chk("rw_rvalid", 32'(rvalid3), 32'h0);
    chk("rw_rdata", rdata3, 32'h0);
    chk("rw_err", 32'(err3), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (rvalid3) stray++;
    end
    chk("rw_no_rvalid", 32'(stray), 32'h0);
    txn(1, 0, F3_W, 32'h50, 32'h0, rd, er, lat);
    chk("rw_word_kept", rd, 32'h13572468);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
